// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: job sequencer for a single multiply-accumulate processing
// element. It accepts a job (length N, optional external preload), walks the
// operand stream one element per accepted handshake, and drives the MACC
// control lines (gate, exter, clear) plus the psum write-back enable.
//
// Handshake: op_valid/op_ready follow strict valid/ready semantics. An
// operand pair transfers in any cycle where both are high. op_ready is
// only asserted in RUN, where it mirrors op_valid, so the controller never
// back-pressures a present operand while a job is running.
//
// Timing model: the MACC registers its selected adder input, so a term
// issued in cycle t is summed and written back in cycle t+1. psum_we and
// clear are therefore registered copies of "issued last cycle" and "that
// issue was the job's first".
//
// A zero-length job without preload has no real term to issue. The start
// cycle in IDLE is used as the dummy issue, because IDLE already drives
// gate=1 and exter=0. The following DRAIN cycle writes back with clear=1,
// which leaves psum at zero.
module pe_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_preload,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [LEN_W-1:0] op_idx,
  output logic             gate,
  output logic             exter,
  output logic             clear,
  output logic             psum_we,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic             r_pre;
  logic [LEN_W-1:0] r_idx;
  logic             r_psum_we;
  logic             r_clear;
  logic             r_first;

  logic             w_accept;
  logic             w_dummy;
  logic             w_run_issue;
  logic             w_last;
  logic             w_issue;

  // Issue/accept qualifiers shared by the FSM and the write-back pipeline.
  always_comb begin
    w_accept    = 1'b0;
    w_dummy     = 1'b0;
    w_run_issue = 1'b0;
    w_last      = 1'b0;
    w_issue     = 1'b0;
    w_accept    = (r_state == S_IDLE) && start;
    w_dummy     = w_accept && !cfg_preload && (cfg_len == LEN_ZERO);
    w_run_issue = (r_state == S_RUN) && op_valid;
    w_last      = w_run_issue && (r_idx == (r_len - LEN_ONE));
    w_issue     = (r_state == S_PRELOAD) || w_run_issue || w_dummy;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and MACC control decode.
  always_comb begin
    w_next   = r_state;
    gate     = 1'b1;
    exter    = 1'b0;
    op_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_preload) begin
            w_next = S_PRELOAD;
          end else if (cfg_len != LEN_ZERO) begin
            w_next = S_RUN;
          end else begin
            w_next = S_DRAIN;
          end
        end
      end
      S_PRELOAD: begin
        exter = 1'b1;
        if (r_len != LEN_ZERO) begin
          w_next = S_RUN;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_RUN: begin
        op_ready = op_valid;
        gate     = !op_valid;
        if (w_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Job configuration is captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= LEN_ZERO;
      r_pre <= 1'b0;
    end else if (w_accept) begin
      r_len <= cfg_len;
      r_pre <= cfg_preload;
    end
  end

  // Element index: advances per consumed operand, holds N-1 on the last
  // one so it never passes the job length, and returns to 0 for IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= LEN_ZERO;
    end else if (w_accept || (r_state == S_DRAIN)) begin
      r_idx <= LEN_ZERO;
    end else if (w_run_issue && !w_last) begin
      r_idx <= r_idx + LEN_ONE;
    end
  end

  // First-term tracker: armed on accept, consumed by the first issue, so a
  // pending clear rides through any stalls before that issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= 1'b0;
    end else if (w_accept && !w_dummy) begin
      r_first <= 1'b1;
    end else if (w_issue) begin
      r_first <= 1'b0;
    end
  end

  // Write-back pipeline: one cycle behind the issue that produced the term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psum_we <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_psum_we <= w_issue;
      r_clear   <= w_issue && (w_dummy || r_first);
    end
  end

  // Status outputs. DRAIN is always the write-back of the last issued term.
  always_comb begin
    op_idx    = r_idx;
    psum_we   = r_psum_we;
    clear     = r_clear;
    busy      = (r_state != S_IDLE);
    done      = r_psum_we && (r_state == S_DRAIN);
    dbg_state = r_state;
  end

  // r_pre is retained for debug visibility of the latched job mode.
  logic w_pre_unused;
  always_comb begin
    w_pre_unused = r_pre;
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed testbench for pe_seq_ctrl with a behavioural MACC datapath model
// so that final psum values can be compared against hand-computed numbers.
module tb_pe_seq_ctrl;

  localparam int LEN_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_preload;
  logic             op_valid;
  logic             op_ready;
  logic [LEN_W-1:0] op_idx;
  logic             gate;
  logic             exter;
  logic             clear;
  logic             psum_we;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  pe_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_preload (cfg_preload),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_idx      (op_idx),
    .gate        (gate),
    .exter       (exter),
    .clear       (clear),
    .psum_we     (psum_we),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- MACC datapath model ----------------
  int   a_v = 0;
  int   b_v = 0;
  int   ext_v = 0;
  int   m_prod = 0;
  int   m_ext = 0;
  logic m_exsel = 1'b0;
  int   m_psum = 0;
  int   m_acc;

  assign m_acc = m_prod + (m_exsel ? m_ext : (clear ? 0 : m_psum));

  always @(posedge clk) begin
    if (psum_we) m_psum <= m_acc;
    m_prod  <= gate ? 0 : a_v * b_v;
    m_exsel <= exter;
    m_ext   <= ext_v;
  end

  // ---------------- event monitor ----------------
  int   n_we = 0;
  int   n_clr = 0;
  int   n_busy = 0;
  int   n_done = 0;
  int   n_ext = 0;
  logic first_clr = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (psum_we) begin
        if (n_we == 0) first_clr = clear;
        n_we++;
      end
      if (clear) n_clr++;
      if (busy)  n_busy++;
      if (done)  n_done++;
      if (exter) n_ext++;
    end
  end

  task automatic mon_reset();
    n_we = 0; n_clr = 0; n_busy = 0; n_done = 0; n_ext = 0; first_clr = 1'b0;
  endtask

  // ---------------- scoring ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_psum_we"},  psum_we,  0);
    chk({tag, "_clear"},    clear,    0);
    chk({tag, "_exter"},    exter,    0);
    chk({tag, "_gate"},     gate,     1);
    chk({tag, "_op_ready"}, op_ready, 0);
    chk({tag, "_op_idx"},   op_idx,   0);
  endtask

  // ---------------- driver: one complete job ----------------
  // Called at a falling edge with the DUT idle.
  task automatic run_job(input string tag, input int len, input bit pre,
                         input int ext, input int a, input int b,
                         input int stall_n, input int exp_busy,
                         input int exp_we, input int exp_psum,
                         input int exp_ext);
    int  stalls;
    bit  got;
    mon_reset();
    cfg_len     = LEN_W'(len);
    cfg_preload = pre;
    ext_v = ext; a_v = a; b_v = b;
    op_valid = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    cfg_len     = 8'hA5;
    cfg_preload = ~pre;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (stall_n > 0 && op_idx == 1 && stalls < stall_n) begin
        op_valid = 1'b0;
        stalls++;
        #1;
        chk({tag, "_stall_gate"},  gate,     1);
        chk({tag, "_stall_idx"},   op_idx,   1);
        chk({tag, "_stall_ready"}, op_ready, 0);
        if (stalls > 1) chk({tag, "_stall_we"}, psum_we, 0);
      end else begin
        op_valid = 1'b1;
      end
      #1;
      if (done) begin
        got = 1'b1;
        chk({tag, "_done_with_we"}, psum_we, 1);
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, got, 1);
    @(negedge clk);
    op_valid = 1'b0;
    chk({tag, "_busy_cycles"}, n_busy, exp_busy);
    chk({tag, "_we_count"},    n_we,   exp_we);
    chk({tag, "_clear_count"}, n_clr,  1);
    chk({tag, "_first_clear"}, first_clr, 1);
    chk({tag, "_done_count"},  n_done, 1);
    chk({tag, "_exter_count"}, n_ext,  exp_ext);
    chk({tag, "_psum"},        m_psum, exp_psum);
    chk({tag, "_idle_busy"},   busy,   0);
    chk({tag, "_idle_idx"},    op_idx, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pat;
    bit         hit;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_preload = 1'b0; op_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("idle");

    // N=4, no preload, 2*2 per term.
    run_job("len4", 4, 1'b0, 0, 2, 2, 0, 5, 4, 16, 0);
    // N=3 with preload 100, 3*5 per term.
    run_job("pre3", 3, 1'b1, 100, 3, 5, 0, 5, 4, 145, 1);
    // N=3, two stall cycles after element 0.
    run_job("stall3", 3, 1'b0, 0, 3, 5, 2, 6, 3, 45, 0);
    // N=0 without preload: dummy issue, clear to zero.
    run_job("len0", 0, 1'b0, 0, 9, 9, 0, 1, 1, 0, 0);
    // N=0 with preload of -7.
    run_job("pre0", 0, 1'b1, -7, 9, 9, 0, 2, 1, -7, 1);

    // Reset in the middle of an N=8 job at op_idx=3.
    cfg_len = 8'd8; cfg_preload = 1'b0; a_v = 1; b_v = 1; op_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (op_idx == 3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_idx3", hit, 1);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    mon_reset();
    repeat (3) @(negedge clk);
    chk("rst_no_we",   n_we,   0);
    chk("rst_no_done", n_done, 0);
    chk("rst_idle",    busy,   0);
    run_job("post_rst", 2, 1'b0, 0, 3, 3, 0, 3, 2, 18, 0);

    // start held high: jobs separated by one IDLE cycle.
    mon_reset();
    cfg_len = 8'd2; cfg_preload = 1'b0; a_v = 1; b_v = 1; op_valid = 1'b1;
    start = 1'b1;
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat = {pat[6:0], busy};
    end
    start = 1'b0;
    chk("b2b_busy_pattern", pat, 8'b1110_1110);
    chk("b2b_done_count",   n_done, 2);
    chk("b2b_we_count",     n_we,   4);
    chk("b2b_psum",         m_psum, 2);
    repeat (4) @(negedge clk);
    chk("b2b_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameter: LEN_W, default 8, width of the vector-length configuration and element index.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  job request; sampled only in IDLE.
REQ-005 Port: cfg_len  in  LEN_W  number of multiply-accumulate steps N for the job; latched on accepted start.
REQ-006 Port: cfg_preload  in  1  1 = seed accumulation from external_psum before the products; latched on accepted start.
REQ-007 Port: op_valid  in  1  operand pair (a,b) for element op_idx is present on the MACC inputs.
REQ-008 Port: op_ready  out  1  controller consumes the current operand pair this cycle.
REQ-009 Port: op_idx  out  LEN_W  index of the next element to consume, 0..N-1.
REQ-010 Port: gate  out  1  MACC multiplier gate; 1 forces product 0.
REQ-011 Port: exter  out  1  MACC adder input select; 1 = external_psum.
REQ-012 Port: clear  out  1  MACC clear; zeroes the internal_psum operand.
REQ-013 Port: psum_we  out  1  write-enable for the psum register capturing accum_out into internal_psum.
REQ-014 Port: busy  out  1  job in progress.
REQ-015 Port: done  out  1  single-cycle pulse coincident with the final psum_we of a job.

Function
REQ-016 The MACC registers its selected adder input one cycle after issue; a term issued in cycle t appears on accum_out in cycle t+1 and is written back by psum_we in t+1.
REQ-017 FSM states: IDLE, PRELOAD, RUN, DRAIN; IDLE->PRELOAD on start with cfg_preload=1, IDLE->RUN on start with cfg_preload=0 and N>0, IDLE->DRAIN-via-dummy on start with cfg_preload=0 and N=0.
REQ-018 PRELOAD lasts exactly one cycle: exter=1, gate=1, op_ready=0; next state RUN if N>0, else DRAIN.
REQ-019 RUN: op_ready=op_valid, gate=!op_valid, exter=0; each cycle with op_valid=1 issues one product and increments op_idx.
REQ-020 RUN with op_valid=0 is a stall: gate=1, no issue, op_idx holds, no write-back follows.
REQ-021 RUN->DRAIN in the cycle after the N-th product issues; op_ready=0 in DRAIN; DRAIN->IDLE after one cycle.
REQ-022 N=0 without preload: one gated dummy issue (gate=1, exter=0), followed by one write-back with clear=1, leaving psum=0.
REQ-023 psum_we registered: 1 in the cycle after each issue (preload, product or dummy), 0 after stalls.
REQ-024 clear registered: 1 only on the first write-back of a job; a pending clear survives stalls until that write-back.
REQ-025 done = psum_we of the job's last issued term; busy=1 from the cycle after accepted start through the done cycle.
REQ-026 In IDLE: gate=1, exter=0, op_ready=0, op_idx=0; start while busy is ignored, cfg changes while busy ignored.
REQ-027 Back-to-back: start asserted in the done cycle is ignored; earliest next accepted start is the first IDLE cycle.
REQ-028 op_idx never exceeds N-1; op_idx counter wraps nothing, as N<=2^LEN_W-1.
REQ-029 Job cycles without stalls: N+1 (no preload), N+2 (preload), from first busy cycle to done inclusive.

Reset
REQ-030 rst asynchronously forces IDLE, busy=0, done=0, psum_we=0, clear=0, exter=0, gate=1, op_ready=0, op_idx=0, latched config=0.
REQ-031 rst mid-job aborts immediately; no further psum_we or done for that job; first start after release begins a fresh job.

Verification
REQ-032 cfg_len=4, preload=0, op_valid=1 always, a=b=2 -> psum_we 4 cycles, clear on first only, final psum=16, done on 4th write-back, busy 5 cycles.
REQ-033 cfg_len=3, preload=1, external_psum=100, a=3,b=5 -> exter=1 one cycle, clear on preload write-back, final psum=145, busy 5 cycles.
REQ-034 cfg_len=3, op_valid low for 2 cycles after element 0 -> gate=1 and op_idx held during stall, no psum_we after stalls, final psum equals unstalled case, done 2 cycles later.
REQ-035 cfg_len=0, preload=0 -> one psum_we with clear=1, psum=0, done same cycle; cfg_len=0, preload=1, external_psum=-7 -> psum=-7, done.
REQ-036 rst pulsed during RUN of cfg_len=8 at op_idx=3 -> all outputs at reset values immediately, no done; new start completes normally.
REQ-037 start held high continuously with cfg_len=2 -> jobs separated by one IDLE cycle, second start during busy ignored.
